cosim_commit_sequencer: RTL and testbench

Buffers per-cycle commit bundles and trap events from the core's retire stage and drains them one record per cycle into the single-lane co-simulation checker port. Sits between the ROB commit interface and the cosim blackbox. It removes the per-cycle multi-lane DPI burst and guarantees in-order presentation: lanes in ascending index, then any trap from the same cycle. It also applies ready/valid backpressure to the retire stage.

---
 rtl/cosim_seq_pkg.sv | 28 ++
 rtl/cosim_lane_compactor.sv | 40 ++++
 rtl/cosim_commit_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_cosim_commit_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cosim_seq_pkg.sv
// -----------------------------------------------------------------------------
// cosim_seq_pkg
// Shared types and constants for the co-simulation commit sequencer.
//   REC_XLEN    : data/PC width carried by every buffered record
//   INST_LEN    : instruction width
//   cosim_rec_t : one buffered record (a commit or a trap)
//   ofs_width() : width of a slot offset able to count 0..COMMIT_WIDTH+1
// -----------------------------------------------------------------------------
package cosim_seq_pkg;

  localparam int REC_XLEN = 64;
  localparam int INST_LEN = 32;

  typedef struct packed {
    logic                is_trap;
    logic [REC_XLEN-1:0] pc;
    logic [INST_LEN-1:0] inst;
    logic [REC_XLEN-1:0] wdata;   // write data for commits, cause for traps
    logic [REC_XLEN-1:0] mstatus;
    logic                check;
  } cosim_rec_t;

  // A full bundle pushes up to commit_width lanes plus one trap record.
  function automatic int ofs_width(input int commit_width);
    return $clog2(commit_width + 2);
  endfunction

endpackage

// File: rtl/cosim_lane_compactor.sv
// -----------------------------------------------------------------------------
// cosim_lane_compactor
// Combinational prefix-sum over the per-lane valid bits. Each valid lane gets
// the slot offset (relative to the FIFO write pointer) it lands in when the
// invalid lanes are squeezed out; the trap record goes right after the last
// valid lane.
//   in_valid  in   per-lane commit valid
//   in_trap   in   trap raised this cycle
//   lane_ofs  out  slot offset of each lane (meaningful only if that lane is valid)
//   trap_ofs  out  slot offset of the trap record
//   push_n    out  total records pushed: popcount(in_valid) + in_trap
// -----------------------------------------------------------------------------
module cosim_lane_compactor #(
  parameter int COMMIT_WIDTH = 2,
  parameter int OFS_W        = 2
) (
  input  logic [COMMIT_WIDTH-1:0]            in_valid,
  input  logic                               in_trap,
  output logic [COMMIT_WIDTH-1:0][OFS_W-1:0] lane_ofs,
  output logic [OFS_W-1:0]                   trap_ofs,
  output logic [OFS_W-1:0]                   push_n
);

  logic [OFS_W-1:0] run_sum;

  // NOTE: blocking assignments are required here; run_sum is a running
  // total that each loop iteration must see updated, and the defaults at the
  // top keep every output driven on every path so no latch is inferred.
  always_comb begin
    run_sum  = '0;
    lane_ofs = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_ofs[i] = run_sum;
      run_sum     = run_sum + OFS_W'(in_valid[i]);
    end
    trap_ofs = run_sum;
    push_n   = run_sum + OFS_W'(in_trap);
  end

endmodule

// File: rtl/cosim_commit_sequencer.sv
// -----------------------------------------------------------------------------
// cosim_commit_sequencer
// Buffers multi-lane retire bundles (plus an optional trap) in a circular FIFO
// and drains them one record per cycle into the single-lane cosim checker.
// Order within a bundle: valid lanes in ascending index, then the trap.
//   clock, reset        clock and synchronous active-low reset
//   in_valid/in_pc/in_inst/in_wdata/in_mstatus/in_check
//                       per-lane retire fields (lane i at [i*XLEN +: XLEN])
//   in_trap, in_cause   trap raised this cycle and its cause
//   in_ready            bundle accepted this cycle (registered-count based)
//   out_valid/out_ready head record handshake
//   out_is_trap/out_pc/out_inst/out_wdata/out_mstatus/out_check
//                       head record fields
//   retired_count       commit records popped (wraps)
//   trap_count          trap records popped (wraps)
// -----------------------------------------------------------------------------
module cosim_commit_sequencer
  import cosim_seq_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int XLEN         = REC_XLEN,
  parameter int DEPTH        = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [COMMIT_WIDTH-1:0]      in_valid,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
  input  logic [32*COMMIT_WIDTH-1:0]   in_inst,
  input  logic [COMMIT_WIDTH-1:0]      in_check,
  input  logic                         in_trap,
  input  logic [XLEN-1:0]              in_cause,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_is_trap,
  output logic [XLEN-1:0]              out_pc,
  output logic [XLEN-1:0]              out_wdata,
  output logic [XLEN-1:0]              out_mstatus,
  output logic [31:0]                  out_inst,
  output logic                         out_check,
  output logic [63:0]                  retired_count,
  output logic [31:0]                  trap_count
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int OFS_W     = ofs_width(COMMIT_WIDTH);
  // Highest occupancy that still leaves room for a full bundle plus a trap.
  localparam int READY_MAX = DEPTH - COMMIT_WIDTH - 1;

  if (XLEN != REC_XLEN) begin : g_bad_xlen
    $error("XLEN must match cosim_seq_pkg::REC_XLEN");
  end
  if ((DEPTH != (1 << PTR_W)) || (DEPTH < COMMIT_WIDTH + 1)) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least COMMIT_WIDTH+1");
  end

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      retired_q, retired_d;
  logic [31:0]      traps_q, traps_d;
  // Cleared by reset so the output fields read zero until the first push,
  // regardless of what the unreset storage happens to hold.
  logic             head_live_q, head_live_d;

  cosim_rec_t mem_q [DEPTH];
  cosim_rec_t head_rec;
  cosim_rec_t out_rec;
  cosim_rec_t lane_rec [COMMIT_WIDTH];
  cosim_rec_t trap_rec;

  logic [COMMIT_WIDTH-1:0][OFS_W-1:0] lane_ofs;
  logic [OFS_W-1:0]                   trap_ofs;
  logic [OFS_W-1:0]                   push_n;
  logic [PTR_W-1:0]                   lane_slot [COMMIT_WIDTH];
  logic [PTR_W-1:0]                   trap_slot;

  logic accept;
  logic pop;

  cosim_lane_compactor #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .OFS_W        (OFS_W)
  ) u_compactor (
    .in_valid (in_valid),
    .in_trap  (in_trap),
    .lane_ofs (lane_ofs),
    .trap_ofs (trap_ofs),
    .push_n   (push_n)
  );

  // Depends on registered occupancy only, so a pop this cycle cannot
  // combinationally reopen the input.
  assign in_ready  = (count_q <= CNT_W'(READY_MAX));
  assign out_valid = (count_q != '0);
  assign accept    = in_ready & ((|in_valid) | in_trap);
  assign pop       = out_valid & out_ready;

  // Record images and destination slots for the incoming bundle.
  always_comb begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_rec[i].is_trap = 1'b0;
      lane_rec[i].pc      = in_pc[i*XLEN +: XLEN];
      lane_rec[i].inst    = in_inst[i*INST_LEN +: INST_LEN];
      lane_rec[i].wdata   = in_wdata[i*XLEN +: XLEN];
      lane_rec[i].mstatus = in_mstatus[i*XLEN +: XLEN];
      lane_rec[i].check   = in_check[i];
      lane_slot[i]        = wr_ptr_q + PTR_W'(lane_ofs[i]);
    end
    trap_rec         = '0;
    trap_rec.is_trap = 1'b1;
    trap_rec.wdata   = in_cause;
    trap_slot        = wr_ptr_q + PTR_W'(trap_ofs);
  end

  // NOTE: the record storage has no reset. Only pointers and count define
  // which entries are live, so clearing the array would cost a wide reset
  // tree for contents that are never observed before being rewritten.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (in_valid[i]) begin
          mem_q[lane_slot[i]] <= lane_rec[i];
        end
      end
      if (in_trap) begin
        mem_q[trap_slot] <= trap_rec;
      end
    end
  end

  assign head_rec = mem_q[rd_ptr_q];

  // Pointers, occupancy and retirement counters.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    retired_d   = retired_q;
    traps_d     = traps_q;
    head_live_d = head_live_q | accept;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
      count_d  = count_d + CNT_W'(push_n);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_d - CNT_W'(1);
      if (head_rec.is_trap) begin
        traps_d = traps_q + 32'd1;
      end else begin
        retired_d = retired_q + 64'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      retired_q   <= '0;
      traps_q     <= '0;
      head_live_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      retired_q   <= retired_d;
      traps_q     <= traps_d;
      head_live_q <= head_live_d;
    end
  end

  // Head fields come straight from storage; when empty they show the stale
  // head, except right after reset where nothing has been written yet.
  always_comb begin
    out_rec = '0;
    if (head_live_q) begin
      out_rec = head_rec;
    end
  end

  assign out_is_trap   = out_rec.is_trap;
  assign out_pc        = out_rec.pc;
  assign out_inst      = out_rec.inst;
  assign out_wdata     = out_rec.wdata;
  assign out_mstatus   = out_rec.mstatus;
  assign out_check     = out_rec.check;
  assign retired_count = retired_q;
  assign trap_count    = traps_q;

endmodule

// File: tb/tb_cosim_commit_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cosim_commit_sequencer
// Directed bench for cosim_commit_sequencer (COMMIT_WIDTH=2, XLEN=64, DEPTH=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Lane fields are derived from the PC: inst = {pc[23:0],8'h13},
// wdata = pc ^ A5A5_0000_0000_0000, mstatus = 0x0000_000A_0000_0000 | lane,
// check = lane index bit 0.
// -----------------------------------------------------------------------------
module tb_cosim_commit_sequencer;

  localparam int CW = 2;
  localparam int XL = 64;

  logic           clock;
  logic           reset;
  logic [CW-1:0]  in_valid;
  logic [XL*CW-1:0] in_pc, in_wdata, in_mstatus;
  logic [32*CW-1:0] in_inst;
  logic [CW-1:0]  in_check;
  logic           in_trap;
  logic [XL-1:0]  in_cause;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic           out_is_trap;
  logic [XL-1:0]  out_pc, out_wdata, out_mstatus;
  logic [31:0]    out_inst;
  logic           out_check;
  logic [63:0]    retired_count;
  logic [31:0]    trap_count;

  int n_checks;
  int n_errors;

  cosim_commit_sequencer #(
    .COMMIT_WIDTH (CW),
    .XLEN         (XL),
    .DEPTH        (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_pc         (in_pc),
    .in_wdata      (in_wdata),
    .in_mstatus    (in_mstatus),
    .in_inst       (in_inst),
    .in_check      (in_check),
    .in_trap       (in_trap),
    .in_cause      (in_cause),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_is_trap   (out_is_trap),
    .out_pc        (out_pc),
    .out_wdata     (out_wdata),
    .out_mstatus   (out_mstatus),
    .out_inst      (out_inst),
    .out_check     (out_check),
    .retired_count (retired_count),
    .trap_count    (trap_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic set_lanes(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1);
    in_valid   = v;
    in_pc      = {pc1, pc0};
    in_inst    = {pc1[23:0], 8'h13, pc0[23:0], 8'h13};
    in_wdata   = {pc1 ^ 64'hA5A5_0000_0000_0000, pc0 ^ 64'hA5A5_0000_0000_0000};
    in_mstatus = {64'h0000_000A_0000_0001, 64'h0000_000A_0000_0000};
    in_check   = 2'b10;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int sent;
    int got;
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    out_ready = 1'b0;
    in_trap   = 1'b0;
    in_cause  = '0;
    set_lanes(2'b11, 64'hAAAA_0000, 64'hAAAA_0004);

    // ---- reset held 2 cycles with lanes offered ----
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_retired", retired_count, 64'd0);
    check("rst_traps", 64'(trap_count), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    reset    = 1'b1;
    in_valid = 2'b00;
    tick();
    check("rst_nothing_pushed", 64'(out_valid), 64'd0);

    // ---- compaction: lane1 only plus trap ----
    set_lanes(2'b10, 64'h0000_0000_0000_DEAD, 64'h0000_0000_8000_0004);
    in_trap  = 1'b1;
    in_cause = 64'h8000_0000_0000_0007;
    check("cmp_no_bypass", 64'(out_valid), 64'd0);
    tick();
    in_valid = 2'b00;
    in_trap  = 1'b0;
    check("cmp_c_valid", 64'(out_valid), 64'd1);
    check("cmp_c_is_trap", 64'(out_is_trap), 64'd0);
    check("cmp_c_pc", out_pc, 64'h0000_0000_8000_0004);
    check("cmp_c_inst", 64'(out_inst), 64'h0000_0000_0000_0413);
    check("cmp_c_wdata", out_wdata, 64'hA5A5_0000_8000_0004);
    check("cmp_c_mstatus", out_mstatus, 64'h0000_000A_0000_0001);
    check("cmp_c_check", 64'(out_check), 64'd1);
    out_ready = 1'b1;
    tick();
    check("cmp_t_valid", 64'(out_valid), 64'd1);
    check("cmp_t_is_trap", 64'(out_is_trap), 64'd1);
    check("cmp_t_wdata", out_wdata, 64'h8000_0000_0000_0007);
    check("cmp_t_pc", out_pc, 64'd0);
    check("cmp_t_inst", 64'(out_inst), 64'd0);
    check("cmp_t_mstatus", out_mstatus, 64'd0);
    check("cmp_t_check", 64'(out_check), 64'd0);
    check("cmp_retired", retired_count, 64'd1);
    tick();
    out_ready = 1'b0;
    check("cmp_empty", 64'(out_valid), 64'd0);
    check("cmp_traps", 64'(trap_count), 64'd1);

    // ---- backpressure: 3 full bundles fill to 6 ----
    for (int k = 0; k < 3; k++) begin
      check("bp_ready_open", 64'(in_ready), 64'd1);
      set_lanes(2'b11, 64'h2000 + 64'(8*k), 64'h2004 + 64'(8*k));
      tick();
    end
    set_lanes(2'b11, 64'h3000, 64'h3004);
    for (int k = 0; k < 2; k++) begin
      check("bp_ready_closed", 64'(in_ready), 64'd0);
      check("bp_head_stable", out_pc, 64'h2000);
      tick();
    end
    in_valid  = 2'b00;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("bp_drain_valid", 64'(out_valid), 64'd1);
      check("bp_drain_pc", out_pc, 64'h2000 + 64'(4*k));
      tick();
    end
    out_ready = 1'b0;
    check("bp_dropped", 64'(out_valid), 64'd0);
    check("bp_retired", retired_count, 64'd7);

    // ---- simultaneous push and pop at count 5 ----
    set_lanes(2'b11, 64'h4000, 64'h4004);
    tick();
    set_lanes(2'b11, 64'h4008, 64'h400C);
    tick();
    set_lanes(2'b01, 64'h4010, 64'h0);
    tick();
    check("sim_ready_at5", 64'(in_ready), 64'd1);
    set_lanes(2'b11, 64'h4014, 64'h4018);
    out_ready = 1'b1;
    tick();
    in_valid = 2'b00;
    check("sim_ready_at6", 64'(in_ready), 64'd0);
    for (int k = 0; k < 6; k++) begin
      check("sim_drain_pc", out_pc, 64'h4004 + 64'(4*k));
      tick();
    end
    out_ready = 1'b0;
    check("sim_empty", 64'(out_valid), 64'd0);
    check("sim_retired", retired_count, 64'd14);

    // ---- wrap: 20 sequential commits, random consumer ----
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        check("wrap_pc", out_pc, 64'h1000 + 64'(4*got));
        got++;
      end
      if (sent < 20 && in_ready) begin
        if (sent % 2 == 0) set_lanes(2'b01, 64'h1000 + 64'(4*sent), 64'h0);
        else               set_lanes(2'b10, 64'h0, 64'h1000 + 64'(4*sent));
        sent++;
      end else begin
        in_valid = 2'b00;
      end
      tick();
    end
    in_valid  = 2'b00;
    out_ready = 1'b0;
    check("wrap_all_seen", 64'(got), 64'd20);
    check("wrap_retired", retired_count, 64'd34);

    // ---- mid-operation reset ----
    set_lanes(2'b11, 64'h5000, 64'h5004);
    tick();
    set_lanes(2'b11, 64'h5008, 64'h500C);
    tick();
    in_valid = 2'b00;
    check("mrst_buffered", 64'(out_valid), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    check("mrst_retired", retired_count, 64'd0);
    check("mrst_traps", 64'(trap_count), 64'd0);
    check("mrst_out_pc", out_pc, 64'd0);
    set_lanes(2'b01, 64'h6000, 64'h0);
    tick();
    in_valid  = 2'b00;
    check("mrst_fresh_valid", 64'(out_valid), 64'd1);
    check("mrst_fresh_pc", out_pc, 64'h6000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("mrst_fresh_popped", 64'(out_valid), 64'd0);
    check("mrst_fresh_retired", retired_count, 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
